// File: rtl/hs32_mem_pkg.sv
// Shared types and defaults for the HS32 memory arbiter: FSM state encoding,
// the latched memory command payload and the starve-limit default.
package hs32_mem_pkg;

  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM_I = 2'd1,
    MEM_E = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Width of a counter that must hold values 0..maxv (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/hs32_mem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and execute
// load/store, with a bounded-starvation guarantee for fetch and flush cancel.
module hs32_mem_arbiter
  import hs32_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqi,
  input  logic [ADDR_W-1:0] addri,
  output logic              acki,
  output logic [DATA_W-1:0] dtri,
  input  logic              flush,
  input  logic              reqe,
  input  logic              rwe,
  input  logic [ADDR_W-1:0] addre,
  input  logic [DATA_W-1:0] dtwe,
  output logic              acke,
  output logic [DATA_W-1:0] dtre,
  output logic              mreq,
  output logic              mrw,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mdtw,
  input  logic              mack,
  input  logic [DATA_W-1:0] mdtr
);

  localparam int unsigned CW = cnt_width(STARVE_MAX);

  state_t          state;
  mem_cmd_t        cmd_q;
  logic [CW-1:0]   starve;
  logic            cancel;
  logic            fetch_ok;
  logic            exec_win;

  // A flushed fetch request is invisible; execute wins unless fetch is starved.
  assign fetch_ok = reqi & ~flush;
  assign exec_win = reqe & (~fetch_ok | (starve != CW'(STARVE_MAX)));

  assign mrw   = cmd_q.rw;
  assign maddr = cmd_q.addr;
  assign mdtw  = cmd_q.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cmd_q  <= '0;
      mreq   <= 1'b0;
      acki   <= 1'b0;
      acke   <= 1'b0;
      dtri   <= '0;
      dtre   <= '0;
      starve <= '0;
      cancel <= 1'b0;
    end else begin
      acki <= 1'b0;
      acke <= 1'b0;
      case (state)
        IDLE: begin
          if (exec_win) begin
            cmd_q <= '{rw: rwe, addr: addre, wdata: dtwe};
            mreq  <= 1'b1;
            state <= MEM_E;
            // exec_win with a live fetch implies starve is below the limit
            if (fetch_ok) starve <= starve + CW'(1);
          end else if (fetch_ok) begin
            cmd_q.rw   <= 1'b0;
            cmd_q.addr <= addri;
            mreq       <= 1'b1;
            cancel     <= 1'b0;
            starve     <= '0;
            state      <= MEM_I;
          end
        end
        MEM_I: begin
          if (flush) cancel <= 1'b1;
          if (mack) begin
            mreq  <= 1'b0;
            state <= DONE;
            if (!(cancel | flush)) begin
              acki <= 1'b1;
              dtri <= mdtr;
            end
          end
        end
        MEM_E: begin
          if (mack) begin
            mreq  <= 1'b0;
            acke  <= 1'b1;
            dtre  <= mdtr;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Directed bench for hs32_mem_arbiter: transaction-level reference model,
// per-cycle output compare, and literal checks on the directed scenarios.
module tb_hs32_mem_arbiter;
  import hs32_mem_pkg::*;

  localparam int unsigned SMAX = STARVE_MAX_DEFAULT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqi = 1'b0, flush = 1'b0, reqe = 1'b0, rwe = 1'b0, mack = 1'b0;
  logic [31:0] addri = '0, addre = '0, dtwe = '0, mdtr = '0;
  logic        acki, acke, mreq, mrw;
  logic [31:0] dtri, dtre, maddr, mdtw;

  always #5 clk = ~clk;

  hs32_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .reqi(reqi), .addri(addri), .acki(acki), .dtri(dtri), .flush(flush),
    .reqe(reqe), .rwe(rwe), .addre(addre), .dtwe(dtwe), .acke(acke), .dtre(dtre),
    .mreq(mreq), .mrw(mrw), .maddr(maddr), .mdtw(mdtw), .mack(mack), .mdtr(mdtr)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, a one-cycle blind window after
  // each completion, and a count of execute wins over a waiting fetch.
  bit          m_busy, m_is_e, m_cancel, m_skip, m_rw, e_acki, e_acke, m_fi;
  logic [31:0] m_addr, m_wd, e_dtri, e_dtre;
  int unsigned m_starve;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_is_e = 0; m_cancel = 0; m_skip = 0; m_rw = 0;
      e_acki = 0; e_acke = 0; m_addr = '0; m_wd = '0; e_dtri = '0; e_dtre = '0;
      m_starve = 0;
    end else begin
      e_acki = 0;
      e_acke = 0;
      m_fi = reqi && !flush;
      if (m_skip) begin
        m_skip = 0;
      end else if (m_busy) begin
        if (!m_is_e && flush) m_cancel = 1;
        if (mack) begin
          m_busy = 0;
          m_skip = 1;
          if (m_is_e) begin
            e_acke = 1; e_dtre = mdtr;
          end else if (!m_cancel) begin
            e_acki = 1; e_dtri = mdtr;
          end
        end
      end else if (reqe && !(m_fi && m_starve >= SMAX)) begin
        m_busy = 1; m_is_e = 1; m_addr = addre; m_rw = rwe; m_wd = dtwe;
        if (m_fi) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      end else if (m_fi) begin
        m_busy = 1; m_is_e = 0; m_addr = addri; m_rw = 0; m_cancel = 0; m_starve = 0;
      end
    end
  end

  // Per-cycle compare plus event counters used by the directed checks.
  bit       chk_en = 0;
  int       n_acki = 0, n_acke = 0, n_mtx = 0;
  logic     prev_mreq = 1'b0;
  logic [9:0] glog = '0;

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("mreq", 32'(mreq), 32'(m_busy));
      check("acki", 32'(acki), 32'(e_acki));
      check("acke", 32'(acke), 32'(e_acke));
      check("dtri", dtri, e_dtri);
      check("dtre", dtre, e_dtre);
      if (m_busy) begin
        check("maddr", maddr, m_addr);
        check("mrw", 32'(mrw), 32'(m_rw));
        if (m_is_e) check("mdtw", mdtw, m_wd);
      end
    end
    if (!reset) begin
      if (mreq && !prev_mreq) begin
        n_mtx++;
        glog = {glog[8:0], (maddr == 32'h40)};
      end
      if (acki) n_acki++;
      if (acke) n_acke++;
    end
    prev_mreq = mreq;
  end

  // Memory responder, run from the stimulus thread at each falling edge.
  int          lat = 1;
  int          rcnt = 0;
  bit          inject = 0;
  logic [31:0] rdata = '0;

  task automatic step();
    @(negedge clk);
    mack = 1'b0;
    mdtr = $urandom;
    if (inject) begin
      mack = 1'b1; mdtr = rdata; inject = 0;
    end else if (mreq) begin
      rcnt++;
      if (rcnt >= lat) begin
        mack = 1'b1; mdtr = rdata; rcnt = 0;
      end
    end else begin
      rcnt = 0;
    end
  endtask

  task automatic wait_ack(input bit is_e, input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (is_e ? acke : acki) begin
        cyc = i;
        return;
      end
    end
  endtask

  initial begin
    int cyc, base, mack_at, ack_at;
    repeat (2) step();
    check("rst_mreq", 32'(mreq), 32'd0);
    check("rst_mrw", 32'(mrw), 32'd0);
    check("rst_acki", 32'(acki), 32'd0);
    check("rst_acke", 32'(acke), 32'd0);
    check("rst_maddr", maddr, 32'd0);
    check("rst_mdtw", mdtw, 32'd0);
    check("rst_dtri", dtri, 32'd0);
    check("rst_dtre", dtre, 32'd0);
    reset = 1'b0;
    chk_en = 1;
    step();

    // Execute read, mack three cycles after mreq
    base = n_acki;
    lat = 4; rdata = 32'hDEADBEEF;
    reqe = 1; rwe = 0; addre = 32'h100; dtwe = $urandom;
    wait_ack(1, 20, cyc);
    reqe = 0;
    check("rd_ack_latency", 32'(cyc), 32'd5);
    check("rd_dtre", dtre, 32'hDEADBEEF);
    check("rd_no_acki", 32'(n_acki - base), 32'd0);
    step();

    // Execute write: command stable until mack, ack the cycle after
    lat = 3; rdata = 32'h0;
    reqe = 1; rwe = 1; addre = 32'h200; dtwe = 32'h12345678;
    mack_at = -1; ack_at = -1;
    for (int i = 0; i < 20 && ack_at < 0; i++) begin
      step();
      if (mreq) begin
        check("wr_mrw", 32'(mrw), 32'd1);
        check("wr_maddr", maddr, 32'h200);
        check("wr_mdtw", mdtw, 32'h12345678);
      end
      if (mack && mack_at < 0) mack_at = i;
      if (acke) ack_at = i;
    end
    reqe = 0;
    check("wr_ack_after_mack", 32'(ack_at - mack_at), 32'd1);
    step();

    // Both held: starvation bound forces every fifth grant to fetch
    base = n_mtx;
    lat = 1; rdata = 32'h5555AAAA;
    reqi = 1; addri = 32'h40; reqe = 1; rwe = 0; addre = 32'h100;
    for (int i = 0; i < 300 && (n_mtx - base) < 10; i++) step();
    reqi = 0; reqe = 0;
    check("grant_count", 32'(n_mtx - base), 32'd10);
    check("grant_order", 32'(glog), 32'b0000100001);
    repeat (4) step();

    // Flush is ignored-fetch in idle: no memory request
    reqi = 1; addri = 32'h44; flush = 1;
    repeat (3) step();
    check("flush_idle_mreq", 32'(mreq), 32'd0);
    reqi = 0; flush = 0;
    step();

    // Flush during MEM_I: transaction completes, no acki
    base = n_acki;
    lat = 4; rdata = 32'h11112222;
    reqi = 1; addri = 32'h40;
    for (int i = 0; i < 10 && !mreq; i++) step();
    check("fl_granted", 32'(mreq), 32'd1);
    flush = 1; reqi = 0;
    step();
    flush = 0;
    check("fl_mreq_held", 32'(mreq), 32'd1);
    for (int i = 0; i < 20 && mreq; i++) step();
    repeat (3) step();
    check("fl_no_acki", 32'(n_acki - base), 32'd0);
    check("fl_idle", 32'(mreq), 32'd0);

    // Flush coinciding with mack also cancels
    base = n_acki;
    lat = 3; rdata = 32'h33334444;
    reqi = 1; addri = 32'h48;
    for (int i = 0; i < 20 && !mack; i++) step();
    flush = 1; reqi = 0;
    step();
    flush = 0;
    repeat (3) step();
    check("flm_no_acki", 32'(n_acki - base), 32'd0);

    // Plain fetch delivers data
    lat = 2; rdata = 32'hCAFEF00D;
    reqi = 1; addri = 32'h80;
    wait_ack(0, 20, cyc);
    reqi = 0;
    check("fetch_latency", 32'(cyc), 32'd3);
    check("fetch_dtri", dtri, 32'hCAFEF00D);
    step();

    // Request held through its ack cycle: only one transaction
    base = n_mtx;
    lat = 2; rdata = 32'h0A0B0C0D;
    reqe = 1; rwe = 0; addre = 32'h300;
    wait_ack(1, 20, cyc);
    check("hold_ack_seen", 32'(cyc > 0), 32'd1);
    step();
    reqe = 0;
    repeat (4) step();
    check("hold_one_txn", 32'(n_mtx - base), 32'd1);

    // Reset mid MEM_E, then a stray mack
    base = n_acke;
    lat = 100;
    reqe = 1; rwe = 1; addre = 32'h100; dtwe = 32'hFFFF0000;
    for (int i = 0; i < 10 && !mreq; i++) step();
    check("rst_mid_granted", 32'(mreq), 32'd1);
    step();
    reset = 1; reqe = 0;
    step();
    reset = 0;
    check("rstm_mreq", 32'(mreq), 32'd0);
    check("rstm_maddr", maddr, 32'd0);
    check("rstm_mdtw", mdtw, 32'd0);
    check("rstm_dtre", dtre, 32'd0);
    rdata = 32'h77777777; inject = 1;
    step();
    repeat (3) step();
    check("rstm_no_acke", 32'(n_acke - base), 32'd0);
    lat = 2; rdata = 32'h0BADCAFE;
    reqe = 1; rwe = 0; addre = 32'h104;
    wait_ack(1, 20, cyc);
    reqe = 0;
    check("rstm_next_latency", 32'(cyc), 32'd3);
    check("rstm_next_dtre", dtre, 32'h0BADCAFE);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hs32_mem_arbiter.md
HS32_MEM_ARBITER -- requirements
Module: hs32_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive execute grants while fetch waits.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on posedge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port reqi, input, 1: fetch request, held until acki.
REQ-005 SHALL have port addri, input, 32: fetch address, stable while reqi=1.
REQ-006 SHALL have port acki, output, 1: one-cycle fetch completion pulse.
REQ-007 SHALL have port dtri, output, 32: fetch read data, valid when acki=1.
REQ-008 SHALL have port flush, input, 1: pipeline flush; cancels the pending fetch result.
REQ-009 SHALL have port reqe, input, 1: execute load/store request, held until acke.
REQ-010 SHALL have port rwe, input, 1: execute direction, 1=write, 0=read.
REQ-011 SHALL have port addre, input, 32: execute address.
REQ-012 SHALL have port dtwe, input, 32: execute write data.
REQ-013 SHALL have port acke, output, 1: one-cycle execute completion pulse.
REQ-014 SHALL have port dtre, output, 32: execute read data, valid when acke=1.
REQ-015 SHALL have port mreq, output, 1: memory request, held until mack.
REQ-016 SHALL have port mrw, output, 1: memory direction.
REQ-017 SHALL have port maddr, output, 32: memory address.
REQ-018 SHALL have port mdtw, output, 32: memory write data.
REQ-019 SHALL have port mack, input, 1: one-cycle memory completion pulse.
REQ-020 SHALL have port mdtr, input, 32: memory read data, valid with mack.

Function
REQ-021 SHALL implement FSM states IDLE, MEM_I, MEM_E and DONE.
REQ-022 In IDLE with no request, SHALL stay in IDLE with mreq=0.
REQ-023 In IDLE with only reqi=1 and flush=0, SHALL latch addri into maddr with mrw=0 and mreq=1, and go to MEM_I on the next cycle.
REQ-024 In IDLE with only reqe=1, SHALL latch addre/rwe/dtwe into maddr/mrw/mdtw with mreq=1, and go to MEM_E.
REQ-025 In IDLE with both requests, SHALL grant execute unless starve count equals STARVE_MAX, in which case it SHALL grant fetch.
REQ-026 Starve counter SHALL increment (saturating at STARVE_MAX) on each execute grant made while reqi=1, and SHALL clear on every fetch grant.
REQ-027 In MEM_I/MEM_E, SHALL hold mreq, maddr, mrw and mdtw constant until mack=1.
REQ-028 On mack in MEM_E, SHALL drive acke=1 and dtre=mdtr (registered) in the following cycle, deassert mreq in that same cycle, and enter DONE.
REQ-029 On mack in MEM_I, SHALL do the same with acki/dtri, unless the fetch is cancelled.
REQ-030 A fetch is cancelled by flush=1 on any cycle from grant up to and including the mack cycle; when cancelled, acki SHALL stay 0 and the read data SHALL be discarded.
REQ-031 Flush SHALL NOT abort the memory transaction; the arbiter SHALL still wait for mack.
REQ-032 DONE SHALL last exactly one cycle, during which no request is sampled; the FSM then returns to IDLE.
REQ-033 Minimum round trip SHALL be: request seen in cycle 0, mreq=1 in cycle 1, mack in cycle k>=1, ack in cycle k+1, IDLE in cycle k+2.
REQ-034 reqi SHALL be ignored in any cycle where flush=1.
REQ-035 acki and acke SHALL never be 1 in the same cycle, and each SHALL be high for one cycle only.
REQ-036 mack received outside MEM_I/MEM_E SHALL be ignored.
REQ-037 dtri/dtre SHALL hold their last value when not acked.

Reset
REQ-038 On reset, SHALL enter IDLE; mreq, mrw, acki and acke SHALL be 0; maddr, mdtw, dtri and dtre SHALL be 0; starve counter SHALL be 0.
REQ-039 Reset SHALL take priority mid-transaction; a mack arriving after reset SHALL be ignored and no ack issued.

Structure
REQ-040 State encodings and the STARVE_MAX default SHALL live in the shared package hs32_mem_pkg.
REQ-041 SHALL be a single module with no sub-modules; the starve counter is inline.

Verification
REQ-042 Only reqe=1 (read, addre=0x100), mack 3 cycles after mreq with mdtr=0xDEADBEEF -> acke pulse, dtre=0xDEADBEEF, acki=0.
REQ-043 reqi and reqe held continuously with STARVE_MAX=4 -> grant order E,E,E,E,I,E,E,E,E,I.
REQ-044 reqi=1 (addri=0x40), flush=1 during MEM_I -> mreq held until mack, acki never asserted, FSM returns to IDLE.
REQ-045 Execute write (rwe=1, addre=0x200, dtwe=0x12345678) -> mrw=1, maddr=0x200, mdtw=0x12345678 stable until mack; acke one cycle after mack.
REQ-046 Reset asserted in MEM_E, followed by mack -> outputs at reset values, no acke, next request serviced normally.
REQ-047 Requester holds req through its ack cycle -> no duplicate grant (DONE blocks it), exactly one memory transaction.
